// File: rtl/regfile_array.sv
// Register-file storage: NREG x WIDTH flops with one synchronous write port,
// a flattened bus of all registers, and two combinational read ports with optional bypass.
module regfile_array #(
    parameter int WIDTH  = 32,
    parameter int NREG   = 32,
    parameter int SELW   = 5,
    parameter int BYPASS = 1
) (
    input  logic                   clock,
    input  logic                   ctrl_reset,
    input  logic                   ctrl_writeEnable,
    input  logic [SELW-1:0]        ctrl_writeReg,
    input  logic [WIDTH-1:0]       data_writeReg,
    input  logic [SELW-1:0]        ctrl_readRegA,
    input  logic [SELW-1:0]        ctrl_readRegB,
    output logic [WIDTH-1:0]       data_readRegA,
    output logic [WIDTH-1:0]       data_readRegB,
    output logic [NREG*WIDTH-1:0]  reg_bus
);

    localparam bit BYP_EN = (BYPASS != 0);

    // Interface is always ready: one write per cycle, no valid/ready handshake.

    logic [NREG-1:0]            wr_en;
    logic [(NREG-1)*WIDTH-1:0]  store_d;
    logic [(NREG-1)*WIDTH-1:0]  store_q;
    logic [WIDTH-1:0]           reg_view [NREG];
    logic                       bypass_a;
    logic                       bypass_b;

    // One-hot write decode; bit 0 is forced low so register 0 is never written.
    always_comb begin
        wr_en = '0;
        if (ctrl_writeEnable) begin
            wr_en[ctrl_writeReg] = 1'b1;
        end
        wr_en[0] = 1'b0;
    end

    // Storage holds registers 1..NREG-1 only; register k lives at slice k-1.
    always_comb begin
        store_d = store_q;
        for (int k = 1; k < NREG; k++) begin
            if (wr_en[k]) begin
                store_d[(k-1)*WIDTH +: WIDTH] = data_writeReg;
            end
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            store_q <= '0;
        end else begin
            store_q <= store_d;
        end
    end

    assign reg_bus = {store_q, {WIDTH{1'b0}}};

    for (genvar g = 0; g < NREG; g++) begin : g_view
        assign reg_view[g] = reg_bus[g*WIDTH +: WIDTH];
    end

    assign bypass_a = BYP_EN && ctrl_writeEnable &&
                      (ctrl_writeReg == ctrl_readRegA) && (ctrl_readRegA != '0);
    assign bypass_b = BYP_EN && ctrl_writeEnable &&
                      (ctrl_writeReg == ctrl_readRegB) && (ctrl_readRegB != '0);

    // Reset forces both read ports to zero even when a bypass would apply.
    always_comb begin
        data_readRegA = reg_view[ctrl_readRegA];
        data_readRegB = reg_view[ctrl_readRegB];
        if (bypass_a) begin
            data_readRegA = data_writeReg;
        end
        if (bypass_b) begin
            data_readRegB = data_writeReg;
        end
        if (ctrl_reset) begin
            data_readRegA = '0;
            data_readRegB = '0;
        end
    end

endmodule
